clint_timer: RTL and testbench

- Machine-level timer (mtime/mtimecmp) peripheral.
- Sits directly upstream of the CSR unit and drives its timer_interrupt input; the CSR unit sets mip.MTIP from that input.
- Memory-mapped through a simple valid/ready request port with a registered response, so software can read the time and arm the next interrupt.

---
 rtl/clint_timer.sv | 147 ++++++++++++++
 tb/tb_clint_timer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_timer.sv
// clint_timer: machine timer (mtime/mtimecmp) behind a valid/ready register port.
// Define CLINT_TIMER_SNAPSHOT_EN to latch mtime_hi on a mtime_lo read for coherent 64-bit reads.
//
// state | meaning
// IDLE  | ready for a request; resp_rdata parked at 0
// RESP  | one-cycle response beat for the request accepted on the previous edge
module clint_timer #(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned MTIME_W  = 64
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        timer_interrupt
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;

  localparam logic [15:0] PRESC_MAX   = 16'(TICK_DIV - 1);
  localparam logic [1:0]  A_MTIME_LO  = 2'd0;
  localparam logic [1:0]  A_MTIME_HI  = 2'd1;
  localparam logic [1:0]  A_MTCMP_LO  = 2'd2;

  state_e               state_q, state_d;
  logic [15:0]          presc_q, presc_d;
  logic [MTIME_W-1:0]   mtime_q, mtime_d;
  logic [MTIME_W-1:0]   mtimecmp_q, mtimecmp_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [31:0]          resp_rdata_q, resp_rdata_d;
  logic                 irq_q, irq_d;

  logic                 tick;
  logic                 accept;
  logic [1:0]           word;
  logic [31:0]          mtime_hi_rd;
  logic                 unused_addr_bits;

  // Word access only: the byte-lane bits carry no meaning.
  assign unused_addr_bits = ^req_addr[1:0];
  assign word             = req_addr[3:2];

  assign req_ready = rst_in && rdy_in && (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign tick      = rdy_in && (presc_q == PRESC_MAX);

`ifdef CLINT_TIMER_SNAPSHOT_EN
  logic [31:0] shadow_q, shadow_d;
  logic        shadow_vld_q, shadow_vld_d;

  always_comb begin
    shadow_d     = shadow_q;
    shadow_vld_d = shadow_vld_q;
    if (accept) begin
      if (word == A_MTIME_LO && !req_we) begin
        shadow_d     = mtime_q[MTIME_W-1:32];
        shadow_vld_d = 1'b1;
      end else if (word == A_MTIME_HI || (word == A_MTIME_LO && req_we)) begin
        shadow_vld_d = 1'b0;
      end
    end
  end

  assign mtime_hi_rd = shadow_vld_q ? shadow_q : mtime_q[MTIME_W-1:32];

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      shadow_vld_q <= shadow_vld_d;
    end
  end
`else
  assign mtime_hi_rd = mtime_q[MTIME_W-1:32];
`endif

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    mtime_d      = mtime_q;
    mtimecmp_d   = mtimecmp_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    irq_d        = irq_q;
    if (rdy_in) begin
      presc_d      = tick ? '0 : presc_q + 16'd1;
      mtime_d      = mtime_q + {{(MTIME_W-1){1'b0}}, tick};
      state_d      = IDLE;
      resp_valid_d = 1'b0;
      resp_rdata_d = '0;
      if (accept) begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        if (req_we) begin
          // An mtime write replaces the old value outright, so a same-cycle tick is lost.
          case (word)
            A_MTIME_LO: mtime_d = {mtime_q[MTIME_W-1:32], req_wdata};
            A_MTIME_HI: mtime_d = {req_wdata, mtime_q[31:0]};
            A_MTCMP_LO: mtimecmp_d[31:0] = req_wdata;
            default:    mtimecmp_d[MTIME_W-1:32] = req_wdata;
          endcase
        end else begin
          case (word)
            A_MTIME_LO: resp_rdata_d = mtime_q[31:0];
            A_MTIME_HI: resp_rdata_d = mtime_hi_rd;
            A_MTCMP_LO: resp_rdata_d = mtimecmp_q[31:0];
            default:    resp_rdata_d = mtimecmp_q[MTIME_W-1:32];
          endcase
        end
      end
      irq_d = (mtime_d >= mtimecmp_d);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      mtime_q      <= '0;
      mtimecmp_q   <= '1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      mtime_q      <= mtime_d;
      mtimecmp_q   <= mtimecmp_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      irq_q        <= irq_d;
    end
  end

  assign resp_valid      = resp_valid_q;
  assign resp_rdata      = resp_rdata_q;
  assign timer_interrupt = irq_q;

endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: two timers (TICK_DIV=1 and 4) share one stimulus stream and are
// compared against a cycle-level behavioural model of the register map.
module tb_clint_timer;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, req_valid, req_we;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        req_ready [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        timer_interrupt [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  clint_timer #(.TICK_DIV(1)) u_dut1 (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .req_valid(req_valid), .req_ready(req_ready[0]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
    .timer_interrupt(timer_interrupt[0])
  );

  clint_timer #(.TICK_DIV(4)) u_dut4 (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .req_valid(req_valid), .req_ready(req_ready[1]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
    .timer_interrupt(timer_interrupt[1])
  );

  // Reference model: mtime advances once every div enabled cycles since reset.
  int          div_of [2] = '{1, 4};
  logic [63:0] m_mtime [2];
  logic [63:0] m_cmp [2];
  longint      m_en [2];
  bit          m_st [2];
  bit          m_rv [2];
  bit          m_irq [2];
  logic [31:0] m_rd [2];
`ifdef CLINT_TIMER_SNAPSHOT_EN
  logic [31:0] m_sh [2];
  bit          m_shv [2];
`endif

  function automatic void model_step(int i);
    logic [63:0] t;
    logic [63:0] c;
    logic [31:0] rd;
    bit          tk;
    bit          acc;
    if (!rst_in) begin
      m_mtime[i] = 64'd0;
      m_cmp[i]   = {64{1'b1}};
      m_en[i]    = 0;
      m_st[i]    = 1'b0;
      m_rv[i]    = 1'b0;
      m_rd[i]    = 32'd0;
      m_irq[i]   = 1'b0;
`ifdef CLINT_TIMER_SNAPSHOT_EN
      m_sh[i]    = 32'd0;
      m_shv[i]   = 1'b0;
`endif
      return;
    end
    if (!rdy_in) return;
    m_en[i]++;
    tk  = (m_en[i] % div_of[i]) == 0;
    acc = req_valid && !m_st[i];
    t   = m_mtime[i] + (tk ? 64'd1 : 64'd0);
    c   = m_cmp[i];
    rd  = 32'd0;
    if (acc && req_we) begin
      case (req_addr[3:2])
        2'd0: t = {m_mtime[i][63:32], req_wdata};
        2'd1: t = {req_wdata, m_mtime[i][31:0]};
        2'd2: c[31:0] = req_wdata;
        default: c[63:32] = req_wdata;
      endcase
`ifdef CLINT_TIMER_SNAPSHOT_EN
      if (req_addr[3] == 1'b0) m_shv[i] = 1'b0;
`endif
    end else if (acc) begin
      case (req_addr[3:2])
        2'd0: begin
          rd = m_mtime[i][31:0];
`ifdef CLINT_TIMER_SNAPSHOT_EN
          m_sh[i]  = m_mtime[i][63:32];
          m_shv[i] = 1'b1;
`endif
        end
        2'd1: begin
`ifdef CLINT_TIMER_SNAPSHOT_EN
          rd = m_shv[i] ? m_sh[i] : m_mtime[i][63:32];
          m_shv[i] = 1'b0;
`else
          rd = m_mtime[i][63:32];
`endif
        end
        2'd2: rd = m_cmp[i][31:0];
        default: rd = m_cmp[i][63:32];
      endcase
    end
    m_mtime[i] = t;
    m_cmp[i]   = c;
    m_rv[i]    = acc;
    m_rd[i]    = rd;
    m_st[i]    = acc;
    m_irq[i]   = (t >= c);
  endfunction

  always @(posedge clk_in) begin
    for (int i = 0; i < 2; i++) model_step(i);
  end

  // Called at a negedge; returns at the negedge of the response cycle.
  task automatic do_req(input bit we, input logic [3:0] addr, input logic [31:0] wd);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    #1;
    while (req_ready[0] !== 1'b1 && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL req_accept_timeout got=no_ready exp=ready addr=%h", addr);
    end
    @(negedge clk_in);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b0; rdy_in = 1'b1; req_valid = 1'b1; req_we = 1'b0;
    req_addr = 4'h0; req_wdata = 32'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (req_ready[i] !== 1'b0) begin
          failures++; $display("FAIL reset_req_ready dut%0d got=%b exp=0", i, req_ready[i]);
        end
        checks++;
        if (resp_valid[i] !== 1'b0) begin
          failures++; $display("FAIL reset_resp_valid dut%0d got=%b exp=0", i, resp_valid[i]);
        end
        checks++;
        if (timer_interrupt[i] !== 1'b0) begin
          failures++; $display("FAIL reset_irq dut%0d got=%b exp=0", i, timer_interrupt[i]);
        end
      end
    end
    req_valid = 1'b0;
    rst_in    = 1'b1;
    do_req(1'b0, 4'hC, 32'd0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (resp_valid[i] !== 1'b1 || resp_rdata[i] !== 32'hFFFF_FFFF) begin
        failures++;
        $display("FAIL reset_cmp_hi dut%0d got=%b/%h exp=1/ffffffff", i, resp_valid[i], resp_rdata[i]);
      end
    end
  endtask

  task automatic test_counting();
    logic [31:0] first [2];
    repeat (40) @(negedge clk_in);
    do_req(1'b0, 4'h0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      first[i] = m_rd[i];
      checks++;
      if (resp_rdata[i] !== m_rd[i]) begin
        failures++; $display("FAIL count_read dut%0d got=%0d exp=%0d", i, resp_rdata[i], m_rd[i]);
      end
    end
    rdy_in = 1'b0;
    repeat (20) @(negedge clk_in);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (resp_valid[i] !== 1'b1 || resp_rdata[i] !== first[i] || req_ready[i] !== 1'b0) begin
        failures++;
        $display("FAIL freeze_hold dut%0d got=v%b d%h r%b exp=v1 d%h r0",
                 i, resp_valid[i], resp_rdata[i], req_ready[i], first[i]);
      end
    end
    rdy_in = 1'b1;
    @(negedge clk_in);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (resp_valid[i] !== 1'b0) begin
        failures++; $display("FAIL freeze_release dut%0d got=%b exp=0", i, resp_valid[i]);
      end
    end
    do_req(1'b0, 4'h0, 32'd0);
    checks++;
    if (resp_rdata[0] !== first[0] + 32'd2) begin
      failures++; $display("FAIL freeze_delta dut0 got=%0d exp=%0d", resp_rdata[0], first[0] + 32'd2);
    end
    checks++;
    if (resp_rdata[1] !== m_rd[1] || (resp_rdata[1] - first[1]) > 32'd1) begin
      failures++; $display("FAIL freeze_delta dut1 got=%0d exp=%0d", resp_rdata[1], m_rd[1]);
    end
  endtask

  task automatic test_interrupt();
    logic [31:0] cmp_lo;
    bit          rose = 1'b0;
    do_req(1'b1, 4'hC, 32'd0);
    cmp_lo = m_mtime[0][31:0] + 32'd20;
    do_req(1'b1, 4'h8, cmp_lo);
    for (int k = 0; k < 40; k++) begin
      checks++;
      if (timer_interrupt[0] !== (m_mtime[0] >= m_cmp[0])) begin
        failures++;
        $display("FAIL irq_level dut0 got=%b exp=%b mtime=%0d", timer_interrupt[0],
                 (m_mtime[0] >= m_cmp[0]), m_mtime[0]);
      end
      checks++;
      if (timer_interrupt[1] !== m_irq[1]) begin
        failures++; $display("FAIL irq_level dut1 got=%b exp=%b", timer_interrupt[1], m_irq[1]);
      end
      if (timer_interrupt[0] === 1'b1) rose = 1'b1;
      @(negedge clk_in);
    end
    checks++;
    if (!rose) begin
      failures++; $display("FAIL irq_rise_timeout got=0 exp=1");
    end
    do_req(1'b1, 4'h8, 32'hFFFF_FFFF);
    checks++;
    if (timer_interrupt[0] !== 1'b0 || timer_interrupt[1] !== m_irq[1]) begin
      failures++;
      $display("FAIL irq_fall got=%b%b exp=0%b", timer_interrupt[0], timer_interrupt[1], m_irq[1]);
    end
  endtask

  task automatic test_carry_wrap();
    do_req(1'b1, 4'h4, 32'hFFFF_FFFF);
    do_req(1'b1, 4'h0, 32'hFFFF_FFFE);
    repeat (2) @(negedge clk_in);
    do_req(1'b0, 4'h0, 32'd0);
    checks++;
    if (resp_rdata[0] !== 32'd0 || resp_rdata[1] !== m_rd[1]) begin
      failures++;
      $display("FAIL wrap_lo got=%h/%h exp=0/%h", resp_rdata[0], resp_rdata[1], m_rd[1]);
    end
    do_req(1'b0, 4'h4, 32'd0);
    checks++;
    if (resp_rdata[0] !== 32'd0 || resp_rdata[1] !== m_rd[1]) begin
      failures++;
      $display("FAIL wrap_hi got=%h/%h exp=0/%h", resp_rdata[0], resp_rdata[1], m_rd[1]);
    end
  endtask

  task automatic test_collision();
    logic [31:0] v;
    for (int k = 0; k < 3; k++) begin
      v = $urandom;
      do_req(1'b1, 4'h0, v);
      do_req(1'b0, 4'h0, 32'd0);
      checks++;
      if (resp_rdata[0] !== v + 32'd1) begin
        failures++; $display("FAIL collide_lo dut0 got=%h exp=%h", resp_rdata[0], v + 32'd1);
      end
      checks++;
      if (resp_rdata[1] !== m_rd[1]) begin
        failures++; $display("FAIL collide_lo dut1 got=%h exp=%h", resp_rdata[1], m_rd[1]);
      end
    end
    v = $urandom;
    do_req(1'b1, 4'h4, v);
    do_req(1'b0, 4'h4, 32'd0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (resp_rdata[i] !== m_rd[i]) begin
        failures++; $display("FAIL collide_hi dut%0d got=%h exp=%h", i, resp_rdata[i], m_rd[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    @(negedge clk_in);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'h8;
    #1;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (resp_valid[0] !== 1'(k % 2) || resp_valid[1] !== 1'(k % 2)) begin
        failures++;
        $display("FAIL b2b_resp_valid cycle%0d got=%b%b exp=%0d", k, resp_valid[0], resp_valid[1], k % 2);
      end
      if (req_ready[0] === 1'b1) acc++;
      @(negedge clk_in);
    end
    req_valid = 1'b0;
    checks++;
    if (acc != 3) begin
      failures++; $display("FAIL b2b_accepts got=%0d exp=3", acc);
    end
  endtask

  task automatic test_reset_mid();
    do_req(1'b0, 4'h0, 32'd0);
    rst_in = 1'b0;
    @(negedge clk_in);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (resp_valid[i] !== 1'b0 || resp_rdata[i] !== 32'd0 || req_ready[i] !== 1'b0 ||
          timer_interrupt[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid dut%0d got=v%b d%h r%b i%b exp=v0 d0 r0 i0", i, resp_valid[i],
                 resp_rdata[i], req_ready[i], timer_interrupt[i]);
      end
    end
    rst_in = 1'b1;
    do_req(1'b0, 4'h4, 32'd0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (resp_rdata[i] !== 32'd0) begin
        failures++; $display("FAIL reset_mid_hi dut%0d got=%h exp=0", i, resp_rdata[i]);
      end
    end
  endtask

  task automatic test_snapshot();
    logic [31:0] exp_hi;
`ifdef CLINT_TIMER_SNAPSHOT_EN
    exp_hi = 32'd0;
`else
    exp_hi = 32'd1;
`endif
    do_req(1'b1, 4'h4, 32'd0);
    do_req(1'b1, 4'h0, 32'hFFFF_FFFE);
    do_req(1'b0, 4'h0, 32'd0);
    checks++;
    if (resp_rdata[0] !== 32'hFFFF_FFFF || resp_rdata[1] !== m_rd[1]) begin
      failures++;
      $display("FAIL snap_lo got=%h/%h exp=ffffffff/%h", resp_rdata[0], resp_rdata[1], m_rd[1]);
    end
    do_req(1'b0, 4'h4, 32'd0);
    checks++;
    if (resp_rdata[0] !== exp_hi || resp_rdata[1] !== m_rd[1]) begin
      failures++;
      $display("FAIL snap_hi got=%h/%h exp=%h/%h", resp_rdata[0], resp_rdata[1], exp_hi, m_rd[1]);
    end
  endtask

  task automatic test_random();
    bit          we;
    logic [3:0]  a;
    logic [31:0] wd;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        rdy_in = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk_in);
        rdy_in = 1'b1;
      end
      we = 1'($urandom_range(0, 1));
      a  = 4'($urandom_range(0, 15));
      wd = $urandom;
      do_req(we, a, wd);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (resp_valid[i] !== 1'b1 || m_rv[i] !== 1'b1 || resp_rdata[i] !== m_rd[i] ||
            timer_interrupt[i] !== m_irq[i]) begin
          failures++;
          $display("FAIL random_op%0d dut%0d got=v%b d%h i%b exp=v1 d%h i%b", n, i, resp_valid[i],
                   resp_rdata[i], timer_interrupt[i], m_rd[i], m_irq[i]);
        end
      end
    end
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_addr = 4'h0; req_wdata = 32'd0;
    test_reset();
    test_counting();
    test_interrupt();
    test_carry_wrap();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    test_snapshot();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
